uart_programmer: RTL and testbench

//  UART bootloader stage upstream of the memory upgrade port (upg_*) on cpu_top.

---
 rtl/uart_programmer.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_programmer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_programmer.sv
// UART bootloader: packs an 8N1 byte stream into little-endian 32-bit words for the upg_* port.
// Optional echo of accepted bytes on tx_o is enabled by defining UART_ECHO_EN.
module uart_programmer #(
  parameter int unsigned CLK_HZ         = 10_000_000,
  parameter int unsigned BAUD           = 128_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upg_start_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o,
  output logic        tx_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMR_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ADR_W        = 15;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADR_W-1:0] ADR_LAST  = {ADR_W{1'b1}};

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {S_IDLE, S_LOAD} sess_state_t;

  // 2-FF synchronizer plus one delay stage for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_accept_c, rx_ferr_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_W'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_accept_c = 1'b0;
    rx_ferr_c   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_accept_c = rx_sync_q;
          rx_ferr_c   = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  sess_state_t      sess_q, sess_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      word_q, word_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             wen_q, wen_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sess_q     <= S_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      timer_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      sess_q     <= sess_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      timer_q    <= timer_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Start pulse overrides any word completion, timeout or address step in the same cycle
  always_comb begin
    sess_d     = sess_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    timer_d    = timer_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    wen_d      = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    if (upg_start_i) begin
      sess_d     = S_LOAD;
      byte_cnt_d = '0;
      timer_d    = '0;
      adr_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      if (rx_ferr_c) err_d = 1'b1;
      if (wen_q) begin
        if (adr_q == ADR_LAST) begin
          done_d = 1'b1;
          sess_d = S_IDLE;
        end else begin
          adr_d = adr_q + ADR_W'(1);
        end
      end
      if (sess_q == S_LOAD) begin
        if (rx_accept_c) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = rx_shift_q;
            2'd1:    word_d[15:8]  = rx_shift_q;
            2'd2:    word_d[23:16] = rx_shift_q;
            default: begin
              dat_d = {rx_shift_q, word_q};
              wen_d = 1'b1;
            end
          endcase
        end else if (timer_q == TMR_LAST) begin
          timer_d    = '0;
          byte_cnt_d = '0;
          done_d     = 1'b1;
          sess_d     = S_IDLE;
          if (byte_cnt_q != 2'd0) err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

`ifdef UART_ECHO_EN
  logic             tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [8:0]       tx_frame_q, tx_frame_d;
  logic [3:0]       tx_left_q, tx_left_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_frame_q <= '1;
      tx_left_q  <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_frame_q <= tx_frame_d;
      tx_left_q  <= tx_left_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Echoes arriving while a frame is still on the line are dropped
  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_frame_d = tx_frame_q;
    tx_left_d  = tx_left_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_busy_q) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_left_q == 4'd0) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_d       = tx_frame_q[0];
          tx_frame_d = {1'b1, tx_frame_q[8:1]};
          tx_left_d  = tx_left_q - 4'd1;
        end
      end
    end else if (rx_accept_c && sess_q == S_LOAD) begin
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_frame_d = {1'b1, rx_shift_q};
      tx_left_d  = 4'd9;
      tx_cnt_d   = '0;
    end
  end

  assign tx_o = tx_q;
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_programmer.sv
// Self-checking bench for uart_programmer: scoreboard of expected memory writes,
// plus direct checks of done/err/address behaviour, timeouts and reset.
module tb_uart_programmer;

  localparam int unsigned CPB = 10;

  logic        clk = 1'b0;
  logic        rst, upg_start_i, rx_i;
  logic        upg_wen_o, upg_done_o, upg_err_o, tx_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;

  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  uart_programmer #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .upg_start_i(upg_start_i),
    .rx_i(rx_i),
    .upg_wen_o(upg_wen_o),
    .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o),
    .upg_err_o(upg_err_o),
    .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      hold(CPB);
    end
    rx_i = stop;
    hold(CPB);
    rx_i = 1'b1;
    hold(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic pulse_start();
    upg_start_i = 1'b1;
    hold(1);
    upg_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int i = 0;
    while (upg_done_o !== 1'b1 && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(upg_done_o), 32'd1);
  endtask

  // Scoreboard monitor: every wen pulse must match the next expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (upg_wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wen_unexpected", 32'(upg_wen_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wen_adr", 32'(upg_adr_o), 32'(e.adr));
          check("wen_dat", upg_dat_o, e.dat);
          @(negedge clk);
          check("wen_single", 32'(upg_wen_o), 32'd0);
          if (e.adr == 15'h7FFF) begin
            check("adr_no_wrap", 32'(upg_adr_o), 32'h7FFF);
            check("done_at_wrap", 32'(upg_done_o), 32'd1);
          end else begin
            check("adr_inc", 32'(upg_adr_o), 32'(e.adr + 15'd1));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    upg_start_i = 1'b0;
    rx_i = 1'b1;
    hold(3);
    check("rst_done", 32'(upg_done_o), 32'd1);
    check("rst_wen", 32'(upg_wen_o), 32'd0);
    check("rst_adr", 32'(upg_adr_o), 32'd0);
    check("rst_dat", upg_dat_o, 32'd0);
    check("rst_err", 32'(upg_err_o), 32'd0);
    check("rst_tx", 32'(tx_o), 32'd1);
    rst = 1'b1;
    hold(2);

    // single word
    pulse_start();
    check("t1_done_low", 32'(upg_done_o), 32'd0);
    exp_q.push_back('{adr: 15'h0000, dat: 32'h12345678});
    send_word(32'h12345678);
    hold(3);
    check("t1_done_stays", 32'(upg_done_o), 32'd0);

    // two words then idle timeout
    pulse_start();
    exp_q.push_back('{adr: 15'h0000, dat: 32'h04030201});
    exp_q.push_back('{adr: 15'h0001, dat: 32'h08070605});
    send_word(32'h04030201);
    send_word(32'h08070605);
    hold(450);
    check("t2_done_before_to", 32'(upg_done_o), 32'd0);
    wait_done("t2_done_timeout", 200);
    check("t2_err", 32'(upg_err_o), 32'd0);
    send_word(32'hDEADBEEF);
    hold(5);
    check("t2_done_after", 32'(upg_done_o), 32'd1);
`ifndef UART_ECHO_EN
    check("t2_tx_tied", 32'(tx_o), 32'd1);
`endif

    // partial word then timeout
    pulse_start();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    hold(450);
    check("t3_done_before_to", 32'(upg_done_o), 32'd0);
    wait_done("t3_done_timeout", 200);
    check("t3_err_partial", 32'(upg_err_o), 32'd1);
    pulse_start();
    check("t3_err_cleared", 32'(upg_err_o), 32'd0);
    check("t3_done_low", 32'(upg_done_o), 32'd0);

    // framing error, then a good word, then a glitch
    send_byte(8'h5A, 1'b0);
    hold(1);
    check("t4_ferr", 32'(upg_err_o), 32'd1);
    exp_q.push_back('{adr: 15'h0000, dat: 32'h44332211});
    send_word(32'h44332211);
    hold(3);
    check("t4_err_sticky", 32'(upg_err_o), 32'd1);
    pulse_start();
    rx_i = 1'b0;
    hold(3);
    rx_i = 1'b1;
    hold(40);
    check("t4_glitch_err", 32'(upg_err_o), 32'd0);
    exp_q.push_back('{adr: 15'h0000, dat: 32'hA4A3A2A1});
    send_word(32'hA4A3A2A1);
    hold(3);

    // top-of-memory boundary
    pulse_start();
    @(negedge clk);
    force dut.adr_q = 15'h7FFE;
    hold(2);
    @(negedge clk);
    release dut.adr_q;
    hold(1);
    check("t5_preload", 32'(upg_adr_o), 32'h7FFE);
    exp_q.push_back('{adr: 15'h7FFE, dat: 32'hCAFEF00D});
    exp_q.push_back('{adr: 15'h7FFF, dat: 32'h0BADC0DE});
    send_word(32'hCAFEF00D);
    send_word(32'h0BADC0DE);
    hold(3);
    check("t5_done", 32'(upg_done_o), 32'd1);
    send_word(32'h55667788);
    hold(3);
    check("t5_adr_hold", 32'(upg_adr_o), 32'h7FFF);

    // reset in the middle of a byte
    pulse_start();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    rx_i = 1'b0;
    hold(CPB);
    rx_i = 1'b1;
    hold(25);
    rst = 1'b0;
    hold(1);
    check("t6_done", 32'(upg_done_o), 32'd1);
    check("t6_wen", 32'(upg_wen_o), 32'd0);
    check("t6_adr", 32'(upg_adr_o), 32'd0);
    check("t6_dat", upg_dat_o, 32'd0);
    check("t6_err", 32'(upg_err_o), 32'd0);
    check("t6_tx", 32'(tx_o), 32'd1);
    rst = 1'b1;
    hold(2);
    pulse_start();
    exp_q.push_back('{adr: 15'h0000, dat: 32'h12345678});
`ifdef UART_ECHO_EN
    fork
      send_word(32'h12345678);
      begin
        logic [7:0] echo;
        int         n;
        n = 0;
        while (tx_o !== 1'b0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        check("t6_echo_start", 32'(tx_o), 32'd0);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          echo[i] = tx_o;
        end
        check("t6_echo_byte", 32'(echo), 32'h78);
        repeat (CPB) @(negedge clk);
        check("t6_echo_stop", 32'(tx_o), 32'd1);
      end
    join
`else
    send_word(32'h12345678);
    check("t6_tx_tied", 32'(tx_o), 32'd1);
`endif
    hold(3);
    check("t6_done_stays", 32'(upg_done_o), 32'd0);

    hold(20);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
